// File: rtl/mem_block_mover_pkg.sv
// mem_mover_pkg: shared constants for mem_block_mover (modes, FSM states, default widths)
package mem_mover_pkg;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam logic MODE_FILL = 1'b0;
    localparam logic MODE_COPY = 1'b1;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FILL_WR = 3'd1;
    localparam logic [2:0] S_CP_RD   = 3'd2;
    localparam logic [2:0] S_CP_WAIT = 3'd3;
    localparam logic [2:0] S_CP_WR   = 3'd4;
    localparam logic [2:0] S_FINISH  = 3'd5;
endpackage

// File: rtl/mem_block_mover_if.sv
// mem_block_mover_if: command strobe/status plus Avalon-MM master bus of the block mover
interface mem_block_mover_if #(
    parameter int ADDR_W = mem_mover_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_mover_pkg::DATA_W_DEF
);
    logic              cmd_start;
    logic              cmd_mode;
    logic [ADDR_W-1:0] cmd_src;
    logic [ADDR_W-1:0] cmd_dst;
    logic [ADDR_W:0]   cmd_len;
    logic [DATA_W-1:0] cmd_pattern;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] m_address;
    logic              m_chipselect;
    logic              m_write;
    logic [3:0]        m_byteenable;
    logic              m_clken;
    logic [DATA_W-1:0] m_writedata;
    logic [DATA_W-1:0] m_readdata;
    modport master (
        input  cmd_start, cmd_mode, cmd_src, cmd_dst, cmd_len, cmd_pattern, m_readdata,
        output busy, done, m_address, m_chipselect, m_write, m_byteenable, m_clken, m_writedata
    );
    modport slave (
        output cmd_start, cmd_mode, cmd_src, cmd_dst, cmd_len, cmd_pattern, m_readdata,
        input  busy, done, m_address, m_chipselect, m_write, m_byteenable, m_clken, m_writedata
    );
endinterface

// File: rtl/mem_block_mover.sv
// mem_block_mover: Avalon-MM block fill/copy engine; defining MEM_MOVER_CHECKSUM_EN adds a checksum of written words
module mem_block_mover
    import mem_mover_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_block_mover_if.master bus
`ifdef MEM_MOVER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);
    localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [ADDR_W:0]   LEN_MAX   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(READ_LATENCY - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d, len_q, len_d, cnt_inc;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, addr_q, addr_d;
    logic [DATA_W-1:0] pat_q, pat_d, wdata_q, wdata_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              busy_q, busy_d, done_q, done_d, cs_q, cs_d, wr_q, wr_d, last;

    assign cnt_inc = cnt_q + 1'b1;
    assign last    = (cnt_inc == len_q);

    // Next state and the registered bus outputs for the cycle that state will occupy
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        src_d   = src_q;
        dst_d   = dst_q;
        pat_d   = pat_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        case (state_q)
            S_IDLE: if (bus.cmd_start) begin
                src_d  = bus.cmd_src;
                dst_d  = bus.cmd_dst;
                pat_d  = bus.cmd_pattern;
                len_d  = (bus.cmd_len > LEN_MAX) ? LEN_MAX : bus.cmd_len;
                cnt_d  = '0;
                busy_d = 1'b1;
                if (bus.cmd_len == '0) begin
                    state_d = S_FINISH;
                end else if (bus.cmd_mode == MODE_FILL) begin
                    state_d = S_FILL_WR;
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                    addr_d  = bus.cmd_dst;
                    wdata_d = bus.cmd_pattern;
                end else begin
                    state_d = S_CP_RD;
                    cs_d    = 1'b1;
                    addr_d  = bus.cmd_src;
                end
            end
            S_FILL_WR, S_CP_WR: begin
                cnt_d = cnt_inc;
                if (last) begin
                    state_d = S_FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (state_q == S_FILL_WR) begin
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                    addr_d  = dst_q + cnt_inc[ADDR_W-1:0];
                    wdata_d = pat_q;
                end else begin
                    state_d = S_CP_RD;
                    cs_d    = 1'b1;
                    addr_d  = src_q + cnt_inc[ADDR_W-1:0];
                end
            end
            S_CP_RD: begin
                state_d = S_CP_WAIT;
                wait_d  = WAIT_INIT;
            end
            S_CP_WAIT: if (wait_q == '0) begin
                state_d = S_CP_WR;
                cs_d    = 1'b1;
                wr_d    = 1'b1;
                addr_d  = dst_q + cnt_q[ADDR_W-1:0];
                wdata_d = bus.m_readdata;
            end else begin
                wait_d = wait_q - 1'b1;
            end
            S_FINISH: if (done_q) begin
                state_d = S_IDLE;
            end else begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any command in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            pat_q   <= '0;
            wait_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            pat_q   <= pat_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
        end
    end

`ifdef MEM_MOVER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;
    // Running sum of words as they go out on the bus; cleared when a command is accepted
    always_ff @(posedge clk) begin
        if (reset || (state_q == S_IDLE && bus.cmd_start)) sum_q <= '0;
        else if (cs_q && wr_q) sum_q <= sum_q + wdata_q;
    end
    assign checksum = sum_q;
`endif

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.m_address    = addr_q;
    assign bus.m_chipselect = cs_q;
    assign bus.m_write      = wr_q;
    assign bus.m_writedata  = wdata_q;
    assign bus.m_byteenable = 4'hF;
    assign bus.m_clken      = 1'b1;
endmodule

// File: tb/tb_mem_block_mover.sv
// tb_mem_block_mover: directed and random fill/copy commands checked against a word-array model
`timescale 1ns/1ps
module tb_mem_block_mover;
    import mem_mover_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_block_mover_if #(.ADDR_W(10), .DATA_W(32)) bus();
`ifdef MEM_MOVER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    mem_block_mover #(.ADDR_W(10), .DATA_W(32), .READ_LATENCY(1)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef MEM_MOVER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    logic [9:0]  raddr;
    int n_wr, n_cs;
    int n_checks, n_errors;

    always @(posedge clk) begin
        if (bus.m_chipselect && bus.m_write) mem[bus.m_address] <= bus.m_writedata;
        raddr <= bus.m_address;
        n_cs  <= n_cs + int'(bus.m_chipselect);
        n_wr  <= n_wr + int'(bus.m_chipselect && bus.m_write);
    end
    assign bus.m_readdata = mem[raddr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mem_diff();
        int bad = 0;
        for (int a = 0; a < 1024; a++) if (mem[a] !== ref_mem[a]) bad++;
        return bad;
    endfunction

    task automatic run_cmd(input logic mode, input int src, input int dst, input int len,
                           input logic [31:0] pat, input int poke);
        int n, k, exp_lat, w0, c0;
        logic [31:0] sum;
        n = (len > 1024) ? 1024 : len;
        sum = 0;
        for (int i = 0; i < n; i++) begin
            ref_mem[(dst + i) % 1024] = mode ? ref_mem[(src + i) % 1024] : pat;
            sum += ref_mem[(dst + i) % 1024];
        end
        exp_lat = (n == 0) ? 2 : (mode ? 1 + 3 * n : n + 1);
        @(negedge clk);
        w0 = n_wr;
        c0 = n_cs;
        bus.cmd_mode    = mode;
        bus.cmd_src     = 10'(src);
        bus.cmd_dst     = 10'(dst);
        bus.cmd_len     = 11'(len);
        bus.cmd_pattern = pat;
        bus.cmd_start   = 1'b1;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
            bus.cmd_start = (k == poke);
            if (k == poke) begin
                bus.cmd_mode    = MODE_FILL;
                bus.cmd_dst     = 10'h3C0;
                bus.cmd_len     = 11'd3;
                bus.cmd_pattern = 32'hBAD0BAD0;
            end
            if (k == 1) check("busy_rise", 32'(bus.busy), 1);
        end while (!bus.done && k < 4000);
        check("done_lat", k, exp_lat);
        check("busy_at_done", 32'(bus.busy), 0);
        check("n_writes", n_wr - w0, n);
        check("n_access", n_cs - c0, mode ? 2 * n : n);
`ifdef MEM_MOVER_CHECKSUM_EN
        check("checksum", checksum, sum);
`endif
        @(posedge clk);
        #1;
        bus.cmd_start = 1'b0;
        check("idle_after_done", 32'({bus.busy, bus.done}), 0);
        check("mem", mem_diff(), 0);
    endtask

    initial begin
        int d;
        logic [31:0] p;
        bus.cmd_start   = 1'b0;
        bus.cmd_mode    = MODE_FILL;
        bus.cmd_src     = '0;
        bus.cmd_dst     = '0;
        bus.cmd_len     = '0;
        bus.cmd_pattern = '0;
        for (int a = 0; a < 1024; a++) ref_mem[a] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_cs", 32'(bus.m_chipselect), 0);
        check("rst_write", 32'(bus.m_write), 0);
        check("rst_addr", 32'(bus.m_address), 0);
        check("rst_wdata", bus.m_writedata, 0);
        check("rst_be", 32'(bus.m_byteenable), 32'hF);
        check("rst_clken", 32'(bus.m_clken), 1);
        reset = 1'b0;

        run_cmd(MODE_FILL, 0, 0, 1500, 32'h0, 0);
        run_cmd(MODE_FILL, 0, 'h010, 4, 32'hDEADBEEF, 0);
        run_cmd(MODE_FILL, 0, 'h000, 1, 32'h11, 0);
        run_cmd(MODE_FILL, 0, 'h001, 1, 32'h22, 0);
        run_cmd(MODE_FILL, 0, 'h002, 1, 32'h33, 0);
        run_cmd(MODE_COPY, 'h000, 'h100, 3, 32'h0, 0);
        run_cmd(MODE_COPY, 'h000, 'h200, 0, 32'h0, 0);
        run_cmd(MODE_FILL, 0, 'h200, 0, 32'h5555AAAA, 0);
        run_cmd(MODE_FILL, 0, 'h3FE, 4, 32'hCAFEF00D, 0);
        run_cmd(MODE_FILL, 0, 'h050, 1, 32'hFFFFFFFF, 0);
        run_cmd(MODE_FILL, 0, 'h051, 1, 32'h00000002, 0);
        run_cmd(MODE_COPY, 'h050, 'h060, 2, 32'h0, 0);
        run_cmd(MODE_COPY, 'h100, 'h101, 3, 32'h0, 0);
        run_cmd(MODE_COPY, 'h3FD, 'h010, 5, 32'h0, 4);
        run_cmd(MODE_FILL, 0, 'h020, 2, 32'h12345678, 3);

        p = 32'hA5A50001;
        @(negedge clk);
        bus.cmd_mode    = MODE_FILL;
        bus.cmd_dst     = 10'h300;
        bus.cmd_len     = 11'd5;
        bus.cmd_pattern = p;
        bus.cmd_start   = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_cs", 32'(bus.m_chipselect), 0);
        check("abort_write", 32'(bus.m_write), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_addr", 32'(bus.m_address), 0);
        check("abort_wdata", bus.m_writedata, 0);
`ifdef MEM_MOVER_CHECKSUM_EN
        check("abort_checksum", checksum, 0);
`endif
        ref_mem['h300] = p;
        ref_mem['h301] = p;
        d = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            d += int'(bus.done);
        end
        check("abort_no_done", d, 0);
        check("abort_mem", mem_diff(), 0);

        for (int t = 0; t < 12; t++) begin
            run_cmd(logic'($urandom_range(0, 1)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 24)),
                    $urandom, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
